reg_scoreboard: RTL and testbench
=================================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter CNT_W, default 2, width of each per-register pending-write counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port issue_valid  input  1  an instruction writing issue_wa is issuing this cycle.
REQ-005 SHALL have port issue_wa  input  5  destination register of the issuing instruction.
REQ-006 SHALL have port issue_ready  output  1  issue is accepted this cycle.
REQ-007 SHALL have port wb_we  input  1  writeback write-enable, the same signal that drives the register-file write port.
REQ-008 SHALL have port wb_wa  input  5  writeback destination register.
REQ-009 SHALL have port stallW  input  1  writeback stage stalled; the register-file write is not committed this cycle.
REQ-010 SHALL have port ra1, ra2  input  5 each  source registers being read.
REQ-011 SHALL have port busy1, busy2  output  1 each  the source register has an uncommitted pending write.
REQ-012 SHALL have port flush  input  1  discard all in-flight writes (exception or branch squash).
REQ-013 SHALL have port any_pending  output  1  at least one counter is non-zero.

Function
REQ-014 SHALL keep one CNT_W-bit counter per register 1..31; register 0 has no counter and is never busy.
REQ-015 SHALL define commit = wb_we & ~stallW & (wb_wa != 0); a commit decrements cnt[wb_wa] on the next edge.
REQ-016 SHALL define accept = issue_valid & issue_ready & (issue_wa != 0); an accept increments cnt[issue_wa] on the next edge.
REQ-017 SHALL leave the counter unchanged when accept and commit target the same register in the same cycle.
REQ-018 SHALL drive issue_ready = 0 combinationally when cnt[issue_wa] is all-ones and no same-cycle commit targets issue_wa; it SHALL be 1 otherwise, and 1 when issue_wa = 0.
REQ-019 SHALL never decrement a zero counter; a commit to a register whose count is zero is ignored.
REQ-020 SHALL drive busy1 = (ra1 != 0) & (cnt[ra1] != 0), combinationally from current state; busy2 likewise for ra2.
REQ-021 SHALL, on flush, clear all counters on the next edge; flush overrides a same-cycle accept or commit.
REQ-022 SHALL drive any_pending combinationally as the OR of all counter non-zero flags.
REQ-023 SHALL have zero-cycle lookup latency and a one-cycle update latency.

Reset
REQ-024 SHALL, while rst = 1, clear every counter on the clock edge; rst overrides flush, accept and commit.
REQ-025 SHALL, after reset, present busy1 = busy2 = 0, any_pending = 0 and issue_ready = 1.

Configuration
REQ-026 SHALL, when SCOREBOARD_WB_BYPASS_EN is defined, deassert busyN in the same cycle when cnt[raN] = 1 and commit targets raN, because the value is forwarded from writeback.
REQ-027 SHALL, when SCOREBOARD_WB_BYPASS_EN is undefined, implement busyN strictly per REQ-020.

Structure
REQ-028 SHALL take the register-address width (5) and register count (32) from the shared CPU defines package, not from local literals.
REQ-029 SHALL be flat, with no sub-modules; the counter array is one generate loop.

Verification
REQ-030 SHALL cover: reset, then issue_wa=5 accepted -> next cycle ra1=5 gives busy1=1 and any_pending=1; commit wb_wa=5 -> next cycle busy1=0 and any_pending=0.
REQ-031 SHALL cover: three accepts to r7 with CNT_W=2 -> cnt=3 and issue_ready=0 for issue_wa=7; in the same cycle also commit r7 -> issue_ready=1 and the count stays 3.
REQ-032 SHALL cover: commit to r9 with stallW=1 -> counter unchanged and busy stays 1; stallW=0 on the next cycle -> count decrements.
REQ-033 SHALL cover: issue_wa=0 and ra1=0 -> issue_ready=1, busy1=0, no state change; commit to r3 at count 0 -> count stays 0.
REQ-034 SHALL cover: r4 and r6 pending, then flush together with an accept to r8 -> next cycle all counters are 0 and any_pending=0.
REQ-035 SHALL cover, with SCOREBOARD_WB_BYPASS_EN defined: cnt[r2]=1, ra2=2 and a commit to r2 in the same cycle -> busy2=0 that cycle; without the macro -> busy2=1.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared CPU defines for the register scoreboard.
// Register-file address width and register count.
package reg_scoreboard_pkg;

  localparam int REG_AW = 5;
  localparam int NREGS  = 1 << REG_AW;

  typedef logic [REG_AW-1:0] reg_addr_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard for issue/writeback hazards.
// Optional SCOREBOARD_WB_BYPASS_EN: clear busy on a forwarded last write.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_wa,
  output logic              issue_ready,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_wa,
  input  logic              stallW,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic              busy1,
  output logic              busy2,
  input  logic              flush,
  output logic              any_pending
);

  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] CONE = CNT_W'(1);

  logic [NREGS-1:0][CNT_W-1:0] cnt;
  logic [NREGS-1:0]            nz;

  logic commit;
  logic accept;
  logic hit;
  logic full;

  assign commit = wb_we & ~stallW
                & (wb_wa != '0);
  assign hit    = commit
                & (wb_wa == issue_wa);
  assign full   = (cnt[issue_wa] == CMAX);

  assign issue_ready = (issue_wa == '0)
                     | ~full | hit;

  assign accept = issue_valid & issue_ready
                & (issue_wa != '0);

  // r0 is hardwired zero and never tracked
  assign cnt[0] = '0;
  assign nz[0]  = 1'b0;

  generate
    for (genvar i = 1; i < NREGS; i++)
    begin : g_cnt
      logic [CNT_W-1:0] q;
      logic             inc;
      logic             dec;

      assign inc = accept
                 & (issue_wa == REG_AW'(i));
      assign dec = commit
                 & (wb_wa == REG_AW'(i))
                 & (q != '0);

      always_ff @(posedge clk) begin
        if (rst | flush)
          q <= '0;
        else if (inc & ~dec)
          q <= q + CONE;
        else if (dec & ~inc)
          q <= q - CONE;
      end

      assign cnt[i] = q;
      assign nz[i]  = |q;
    end
  endgenerate

  assign any_pending = |nz;

  logic [CNT_W-1:0] c1;
  logic [CNT_W-1:0] c2;
  logic             byp1;
  logic             byp2;

  assign c1 = cnt[ra1];
  assign c2 = cnt[ra2];

`ifdef SCOREBOARD_WB_BYPASS_EN
  assign byp1 = commit & (wb_wa == ra1)
              & (c1 == CONE);
  assign byp2 = commit & (wb_wa == ra2)
              & (c2 == CONE);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign busy1 = (ra1 != '0)
               & (c1 != '0) & ~byp1;
  assign busy2 = (ra2 != '0)
               & (c2 != '0) & ~byp2;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard.
// Count model plus directed scenarios.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  localparam int CNT_W = 2;
  localparam int CMAXI = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              issue_valid;
  logic [REG_AW-1:0] issue_wa;
  logic              issue_ready;
  logic              wb_we;
  logic [REG_AW-1:0] wb_wa;
  logic              stallW;
  logic [REG_AW-1:0] ra1;
  logic [REG_AW-1:0] ra2;
  logic              busy1;
  logic              busy2;
  logic              flush;
  logic              any_pending;

  int total = 0;
  int fails = 0;
  bit armed = 1'b0;
  int mcnt [NREGS];

  reg_scoreboard #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_wa    (issue_wa),
    .issue_ready (issue_ready),
    .wb_we       (wb_we),
    .wb_wa       (wb_wa),
    .stallW      (stallW),
    .ra1         (ra1),
    .ra2         (ra2),
    .busy1       (busy1),
    .busy2       (busy2),
    .flush       (flush),
    .any_pending (any_pending)
  );

  always #5 clk = ~clk;

  task automatic check(string name,
                       logic act, logic exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b want %b at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic bit m_commit();
    return wb_we && !stallW && wb_wa != 0;
  endfunction

  function automatic bit m_ready();
    if (issue_wa == 0) return 1'b1;
    if (mcnt[issue_wa] < CMAXI) return 1'b1;
    return m_commit() && wb_wa == issue_wa;
  endfunction

  function automatic bit m_busy(int ra);
    bit b;
    b = (ra != 0) && (mcnt[ra] > 0);
`ifdef SCOREBOARD_WB_BYPASS_EN
    if (mcnt[ra] == 1 && m_commit()
        && wb_wa == ra)
      b = 1'b0;
`endif
    return b;
  endfunction

  function automatic bit m_any();
    for (int i = 1; i < NREGS; i++)
      if (mcnt[i] != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Model: counts of outstanding writes
  always @(posedge clk) begin
    bit acc;
    bit com;
    if (rst || flush) begin
      for (int i = 0; i < NREGS; i++)
        mcnt[i] = 0;
    end else begin
      acc = issue_valid && m_ready()
            && issue_wa != 0;
      com = m_commit() && mcnt[wb_wa] > 0;
      if (!(acc && com && issue_wa == wb_wa)) begin
        if (acc) mcnt[issue_wa]++;
        if (com) mcnt[wb_wa]--;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("m_ready", issue_ready, m_ready());
      check("m_busy1", busy1, m_busy(int'(ra1)));
      check("m_busy2", busy2, m_busy(int'(ra2)));
      check("m_any", any_pending, m_any());
    end
  end

  task automatic idle();
    issue_valid = 0; issue_wa = 0;
    wb_we = 0; wb_wa = 0; stallW = 0;
    ra1 = 0; ra2 = 0; flush = 0;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic issue(int wa);
    issue_valid = 1;
    issue_wa = REG_AW'(wa);
    nxt();
  endtask

  task automatic wb(int wa);
    wb_we = 1;
    wb_wa = REG_AW'(wa);
    nxt();
  endtask

  initial begin
    idle();
    rst = 1;
    @(posedge clk); #1;
    armed = 1'b1;
    @(posedge clk); #1;
    rst = 0;

    // Reset state
    issue_wa = 5; ra1 = 5; ra2 = 9;
    @(negedge clk);
    check("rst_ready", issue_ready, 1'b1);
    check("rst_busy1", busy1, 1'b0);
    check("rst_busy2", busy2, 1'b0);
    check("rst_any", any_pending, 1'b0);
    nxt();

    // Issue r5, then retire it
    issue(5);
    ra1 = 5;
    @(negedge clk);
    check("r5_busy", busy1, 1'b1);
    check("r5_any", any_pending, 1'b1);
    nxt();
    wb(5);
    ra1 = 5;
    @(negedge clk);
    check("r5_done", busy1, 1'b0);
    check("r5_none", any_pending, 1'b0);
    nxt();

    // Saturate r7
    issue(7); issue(7); issue(7);
    issue_valid = 1; issue_wa = 7;
    @(negedge clk);
    check("r7_full", issue_ready, 1'b0);
    check("r7_m3", mcnt[7] == 3, 1'b1);
    nxt();
    issue_valid = 1; issue_wa = 7;
    wb_we = 1; wb_wa = 7;
    @(negedge clk);
    check("r7_hit", issue_ready, 1'b1);
    nxt();
    issue_valid = 1; issue_wa = 7;
    @(negedge clk);
    check("r7_hold", issue_ready, 1'b0);
    nxt();
    wb(7); wb(7); wb(7);
    ra1 = 7;
    @(negedge clk);
    check("r7_drain", busy1, 1'b0);
    nxt();

    // Stalled writeback to r9
    issue(9);
    wb_we = 1; wb_wa = 9; stallW = 1; ra1 = 9;
    @(negedge clk);
    check("r9_stall", busy1, 1'b1);
    nxt();
    ra1 = 9;
    @(negedge clk);
    check("r9_kept", busy1, 1'b1);
    nxt();
    wb(9);
    ra1 = 9;
    @(negedge clk);
    check("r9_done", busy1, 1'b0);
    nxt();

    // r0 and zero-count commit
    issue_valid = 1; issue_wa = 0; ra1 = 0;
    @(negedge clk);
    check("r0_ready", issue_ready, 1'b1);
    check("r0_busy", busy1, 1'b0);
    nxt();
    @(negedge clk);
    check("r0_any", any_pending, 1'b0);
    nxt();
    wb(3);
    ra1 = 3;
    @(negedge clk);
    check("r3_zero", busy1, 1'b0);
    check("r3_m0", mcnt[3] == 0, 1'b1);
    nxt();

    // Flush beats a same-cycle accept
    issue(4); issue(6);
    ra1 = 4; ra2 = 6;
    @(negedge clk);
    check("fl_pend", any_pending, 1'b1);
    nxt();
    flush = 1; issue_valid = 1; issue_wa = 8;
    nxt();
    ra1 = 8; ra2 = 4;
    @(negedge clk);
    check("fl_any", any_pending, 1'b0);
    check("fl_r8", busy1, 1'b0);
    check("fl_r4", busy2, 1'b0);
    nxt();

    // Writeback bypass on the last write
    issue(2);
    ra2 = 2; wb_we = 1; wb_wa = 2;
    @(negedge clk);
`ifdef SCOREBOARD_WB_BYPASS_EN
    check("byp_r2", busy2, 1'b0);
`else
    check("byp_r2", busy2, 1'b1);
`endif
    nxt();

    // Reset beats accept
    issue(10);
    rst = 1; issue_valid = 1; issue_wa = 11;
    nxt();
    rst = 0; ra1 = 10; ra2 = 11;
    @(negedge clk);
    check("rr_any", any_pending, 1'b0);
    check("rr_b1", busy1, 1'b0);
    check("rr_b2", busy2, 1'b0);
    nxt();

    // Mixed traffic on two registers
    issue(12); issue(12); issue(13);
    ra1 = 12; ra2 = 13;
    issue_valid = 1; issue_wa = 13;
    wb_we = 1; wb_wa = 12;
    nxt();
    ra1 = 12; ra2 = 13;
    @(negedge clk);
    check("mx_b1", busy1, 1'b1);
    check("mx_m12", mcnt[12] == 1, 1'b1);
    check("mx_m13", mcnt[13] == 2, 1'b1);
    nxt();
    wb(12); wb(13); wb(13);
    @(negedge clk);
    check("mx_any", any_pending, 1'b0);
    nxt();

    $display("%0d/%0d checks passed",
             total - fails, total);
    $finish;
  end

endmodule
